// File: rtl/load_store_unit.sv
// Load/store initiator for a word-organised data memory: word-aligned req/ready
// transactions, sub-word load extension and read-modify-write for SB/SH.
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        err,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   output logic        mem_req,
   input  logic [31:0] mem_RD,
   input  logic        mem_ready
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       off_q, off_d;
   logic             ld_q, ld_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wd_q, wd_d;
   logic [31:0]      ldata_q, ldata_d;
   logic             mis_q, mis_d;
   logic             err_q, err_d;

   logic             illegal;
   logic             unaligned;

   function automatic logic [31:0] extract_load(input logic [31:0] rd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(rd >> {off, 3'b000});
      h = 16'(rd >> {off[1], 4'b0000});
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic        half,
                                               input logic [1:0]  off);
      logic [4:0]  sh;
      logic [31:0] mask;
      logic [31:0] ins;
      if (half) begin
         sh   = {off[1], 4'b0000};
         mask = 32'h0000_FFFF << sh;
         ins  = {16'd0, wd[15:0]} << sh;
      end else begin
         sh   = {off, 3'b000};
         mask = 32'h0000_00FF << sh;
         ins  = {24'd0, wd[7:0]} << sh;
      end
      return (old & ~mask) | ins;
   endfunction

   // Command legality: exactly one of load/store, and BU/HU only for loads
   always_comb begin
      illegal = 1'b0;
      if (is_load == is_store) begin
         illegal = 1'b1;
      end else if (is_load) begin
         illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                     funct3 == 3'b100 || funct3 == 3'b101);
      end else begin
         illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
      end
      unaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      off_d   = off_q;
      ld_d    = ld_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      ldata_d = ldata_q;
      mis_d   = mis_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               f3_d   = funct3;
               off_d  = addr[1:0];
               ld_d   = is_load;
               addr_d = {addr[31:2], 2'b00};
               wd_d   = store_data;
               mis_d  = 1'b0;
               err_d  = 1'b0;
               cnt_d  = '0;
               if (illegal) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (unaligned) begin
                  mis_d   = 1'b1;
                  state_d = S_DONE;
               end else if (is_load || funct3 != 3'b010) begin
                  state_d = S_READ;
               end else begin
                  state_d = S_WRITE;
               end
            end
         end
         S_READ: begin
            if (mem_ready) begin
               cnt_d = '0;
               if (ld_q) begin
                  ldata_d = extract_load(mem_RD, f3_q, off_q);
                  state_d = S_DONE;
               end else begin
                  wd_d    = merge_store(mem_RD, wd_q, f3_q[0], off_q);
                  state_d = S_WRITE;
               end
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WRITE: begin
            if (mem_ready) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         ld_q    <= 1'b0;
         addr_q  <= 32'd0;
         wd_q    <= 32'd0;
         ldata_q <= 32'd0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         ld_q    <= ld_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         ldata_q <= ldata_d;
         mis_q   <= mis_d;
         err_q   <= err_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign load_data  = ldata_q;
   assign misaligned = mis_q;
   assign err        = err_q;
   assign mem_A      = addr_q;
   assign mem_WD     = wd_q;
   assign mem_WE     = (state_q == S_WRITE);
   assign mem_req    = (state_q == S_READ) || (state_q == S_WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        is_load = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic        busy, done, misaligned, err, mem_WE, mem_req;
   logic [31:0] load_data, mem_A, mem_WD, mem_RD;
   logic        mem_ready = 1'b1;

   logic [31:0] mem [0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx = 8'd0;
   logic [31:0] pl_val = 32'd0;
   int          req_cnt = 0;
   int          wr_cnt = 0;

   int n_chk = 0;
   int n_pass = 0;

   load_store_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
      .load_data(load_data), .misaligned(misaligned), .err(err), .mem_A(mem_A),
      .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_req(mem_req), .mem_RD(mem_RD),
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   assign mem_RD = (mem_A[31:10] == 22'd0) ? mem[mem_A[9:2]] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (mem_req) req_cnt <= req_cnt + 1;
      if (mem_req && mem_WE && mem_ready) begin
         mem[mem_A[9:2]] <= mem_WD;
         wr_cnt <= wr_cnt + 1;
      end else if (pl_en) begin
         mem[pl_idx] <= pl_val;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      pl_idx = idx;
      pl_val = val;
      pl_en  = 1'b1;
      @(negedge clk);
      pl_en  = 1'b0;
   endtask

   // Issues one command and returns at the negedge where done is seen (or the bound expires).
   task automatic do_cmd(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, output int lat);
      is_load    = ld;
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = sd;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 2;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic end_cmd(input string tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int lat;
      int r0, w0, dcount;

      // Reset
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, mem_WE}, 32'd0);
      chk("rst_flags", {30'd0, misaligned, err}, 32'd0);
      chk("rst_ld", load_data, 32'd0);
      chk("rst_A", mem_A, 32'd0);
      chk("rst_WD", mem_WD, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Loads with extension
      preload(8'h40, 32'h80AA_5566);
      do_cmd(1, 0, 3'b000, 32'h103, 32'd0, lat);
      chk("lb_data", load_data, 32'hFFFF_FF80);
      chk("lb_lat", lat, 3);
      chk("lb_A", mem_A, 32'h100);
      end_cmd("lb");
      do_cmd(1, 0, 3'b100, 32'h103, 32'd0, lat);
      chk("lbu_data", load_data, 32'h0000_0080);
      end_cmd("lbu");
      do_cmd(1, 0, 3'b001, 32'h102, 32'd0, lat);
      chk("lh_data", load_data, 32'hFFFF_80AA);
      chk("lh_lat", lat, 3);
      end_cmd("lh");
      do_cmd(1, 0, 3'b101, 32'h100, 32'd0, lat);
      chk("lhu_data", load_data, 32'h0000_5566);
      end_cmd("lhu");
      do_cmd(1, 0, 3'b000, 32'h101, 32'd0, lat);
      chk("lb1_data", load_data, 32'h0000_0055);
      end_cmd("lb1");
      do_cmd(1, 0, 3'b010, 32'h100, 32'd0, lat);
      chk("lw_data", load_data, 32'h80AA_5566);
      chk("lw_flags", {30'd0, misaligned, err}, 32'd0);
      end_cmd("lw");

      // Sub-word stores (read-modify-write) and SW
      preload(8'h40, 32'h1122_3344);
      r0 = req_cnt; w0 = wr_cnt;
      do_cmd(0, 1, 3'b000, 32'h101, 32'hFFFF_FF7F, lat);
      chk("sb_lat", lat, 4);
      chk("sb_WD", mem_WD, 32'h1122_7F44);
      chk("sb_mem", mem[8'h40], 32'h1122_7F44);
      chk("sb_reqs", req_cnt - r0, 2);
      chk("sb_writes", wr_cnt - w0, 1);
      end_cmd("sb");
      preload(8'h40, 32'h1122_3344);
      do_cmd(0, 1, 3'b001, 32'h102, 32'hCAFE_BEEF, lat);
      chk("sh_lat", lat, 4);
      chk("sh_mem", mem[8'h40], 32'hBEEF_3344);
      end_cmd("sh");
      r0 = req_cnt;
      do_cmd(0, 1, 3'b010, 32'h104, 32'hA5A5_0001, lat);
      chk("sw_lat", lat, 3);
      chk("sw_mem", mem[8'h41], 32'hA5A5_0001);
      chk("sw_reqs", req_cnt - r0, 1);
      end_cmd("sw");

      // Misaligned accesses never touch memory
      r0 = req_cnt;
      do_cmd(1, 0, 3'b010, 32'h102, 32'd0, lat);
      chk("mis_lw_flags", {30'd0, misaligned, err}, 32'd2);
      chk("mis_lw_lat", lat, 2);
      end_cmd("mis_lw");
      do_cmd(0, 1, 3'b001, 32'h101, 32'h0000_1234, lat);
      chk("mis_sh_flags", {30'd0, misaligned, err}, 32'd2);
      chk("mis_reqs", req_cnt - r0, 0);
      chk("mis_mem", mem[8'h40], 32'hBEEF_3344);
      end_cmd("mis_sh");
      do_cmd(1, 0, 3'b010, 32'h104, 32'd0, lat);
      chk("after_mis_flags", {30'd0, misaligned, err}, 32'd0);
      chk("after_mis_data", load_data, 32'hA5A5_0001);
      end_cmd("after_mis");

      // Timeout during SW
      mem_ready = 1'b0;
      w0 = wr_cnt;
      do_cmd(0, 1, 3'b010, 32'h108, 32'h1234_5678, lat);
      chk("to_lat", lat, 18);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_we_done", {31'd0, mem_WE}, 32'd0);
      mem_ready = 1'b1;
      end_cmd("to");
      chk("to_we_after", {31'd0, mem_WE}, 32'd0);
      chk("to_writes", wr_cnt - w0, 0);

      // Reset in the middle of a write
      mem_ready = 1'b0;
      w0 = wr_cnt;
      is_load = 0; is_store = 1; funct3 = 3'b010; addr = 32'h10C; store_data = 32'h5555_AAAA;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mid_we", {31'd0, mem_WE}, 32'd1);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_we", {31'd0, mem_WE}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
      rst = 1'b1;
      mem_ready = 1'b1;
      dcount = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("mid_no_done", dcount, 0);
      chk("mid_writes", wr_cnt - w0, 0);

      // Illegal commands
      r0 = req_cnt;
      do_cmd(1, 0, 3'b011, 32'h100, 32'd0, lat);
      chk("ill_f3_flags", {30'd0, misaligned, err}, 32'd1);
      chk("ill_f3_lat", lat, 2);
      end_cmd("ill_f3");
      do_cmd(1, 1, 3'b010, 32'h100, 32'd0, lat);
      chk("ill_both_err", {31'd0, err}, 32'd1);
      end_cmd("ill_both");
      do_cmd(0, 1, 3'b100, 32'h100, 32'd0, lat);
      chk("ill_sbu_err", {31'd0, err}, 32'd1);
      end_cmd("ill_sbu");
      chk("ill_reqs", req_cnt - r0, 0);

      // Start re-pulsed while busy is ignored
      mem_ready = 1'b0;
      is_load = 1; is_store = 0; funct3 = 3'b010; addr = 32'h100;
      start = 1'b1;
      @(negedge clk);
      addr = 32'h104;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rep_done", {31'd0, done}, 32'd1);
      chk("rep_data", load_data, 32'hBEEF_3344);
      chk("rep_A", mem_A, 32'h100);
      dcount = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("rep_single_done", dcount, 0);
      chk("rep_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
